// File: rtl/gpu_scanout.sv
// gpu_scanout: reads a monochrome framebuffer from VRAM byte by byte and shifts it MSB-first onto a 2-wire LCD link.
// Build macro GPU_LINE_HEADER_EN: prefix every row with an 8-bit row-index header.
module gpu_scanout #(
    parameter int FB_WIDTH  = 128,
    parameter int FB_HEIGHT = 64,
    parameter int CLK_DIV   = 4
) (
    input  logic                                    sys_clk,
    input  logic                                    sys_rst,
    input  logic                                    frame_start,
    output logic                                    busy,
    output logic                                    frame_done,
    output logic                                    vram_rd_en,
    output logic [$clog2(FB_WIDTH*FB_HEIGHT/8)-1:0] vram_addr,
    input  logic [7:0]                              vram_rdata,
    output logic                                    lcd_clk,
    output logic                                    lcd_data,
    output logic                                    lcd_cs,
    output logic [2:0]                              dbg_state_o
);
    localparam int FB_BYTES = FB_WIDTH * FB_HEIGHT / 8;
    localparam int AW       = $clog2(FB_BYTES);
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [AW-1:0] LAST_BYTE = AW'(FB_BYTES - 1);
    localparam logic [DW-1:0] LAST_DIV  = DW'(CLK_DIV - 1);
`ifdef GPU_LINE_HEADER_EN
    localparam int ROW_BYTES = FB_WIDTH / 8;
    localparam int CW        = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(ROW_BYTES - 1);
`endif

    // Encoding is visible on dbg_state_o: IDLE=0 FETCH=1 LOAD=2 LOW=3 HIGH=4 DONE=5.
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_LOW, S_HIGH, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [AW-1:0] byte_q, byte_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          data_q, data_d;
    logic          pend_q, pend_d;
    logic          start;
`ifdef GPU_LINE_HEADER_EN
    logic          hdr_q, hdr_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    row_q, row_d;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            data_q  <= 1'b0;
            pend_q  <= 1'b0;
`ifdef GPU_LINE_HEADER_EN
            hdr_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
`ifdef GPU_LINE_HEADER_EN
            hdr_q   <= hdr_d;
            col_q   <= col_d;
            row_q   <= row_d;
`endif
        end
    end

    // frame_start is a one-cycle request with no ready: requests made while a frame is
    // in flight are parked in a 1-deep pending flag, and further ones are dropped.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        pend_d  = pend_q;
        start   = 1'b0;
`ifdef GPU_LINE_HEADER_EN
        hdr_d   = hdr_q;
        col_d   = col_q;
        row_d   = row_q;
`endif
        if (frame_start && state_q != S_IDLE) pend_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                byte_d = '0;
                if (frame_start || pend_q) start = 1'b1;
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shreg_d = vram_rdata;
                data_d  = vram_rdata[7];
                bit_d   = '0;
                div_d   = '0;
                state_d = S_LOW;
            end
            S_LOW: begin
                if (div_q == LAST_DIV) begin
                    div_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_HIGH: begin
                if (div_q == LAST_DIV) begin
                    div_d   = '0;
                    shreg_d = {shreg_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q != 3'd7) begin
                        data_d  = shreg_q[6];
                        state_d = S_LOW;
`ifdef GPU_LINE_HEADER_EN
                    end else if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = S_FETCH;
`endif
                    end else if (byte_q == LAST_BYTE) begin
                        state_d = S_DONE;
                    end else begin
                        byte_d  = byte_q + AW'(1);
                        state_d = S_FETCH;
`ifdef GPU_LINE_HEADER_EN
                        // Row boundary: shift out the next row index before its first byte.
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            row_d   = row_q + 8'd1;
                            hdr_d   = 1'b1;
                            shreg_d = row_q + 8'd1;
                            data_d  = row_d[7];
                            state_d = S_LOW;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
`endif
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_DONE: begin
                if (frame_start || pend_q) start = 1'b1;
                else                       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            pend_d  = 1'b0;
            byte_d  = '0;
            bit_d   = '0;
            div_d   = '0;
            state_d = S_FETCH;
`ifdef GPU_LINE_HEADER_EN
            col_d   = '0;
            row_d   = '0;
            hdr_d   = 1'b1;
            shreg_d = '0;
            data_d  = 1'b0;
            state_d = S_LOW;
`endif
        end
    end

    always_comb begin
        busy       = 1'b0;
        lcd_cs     = 1'b0;
        lcd_clk    = 1'b0;
        vram_rd_en = 1'b0;
        vram_addr  = '0;
        frame_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                vram_rd_en = 1'b1;
                vram_addr  = byte_q;
                busy       = 1'b1;
                lcd_cs     = 1'b1;
            end
            S_LOAD, S_LOW: begin
                busy   = 1'b1;
                lcd_cs = 1'b1;
            end
            S_HIGH: begin
                busy    = 1'b1;
                lcd_cs  = 1'b1;
                lcd_clk = 1'b1;
            end
            S_DONE:  frame_done = 1'b1;
            default: ;
        endcase
    end

    assign lcd_data    = data_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_gpu_scanout.sv
// Directed bench for gpu_scanout: a CLK_DIV=1 and a CLK_DIV=3 instance on a 16x2 framebuffer.
// Honours GPU_LINE_HEADER_EN when the bench is built with it.
module tb_gpu_scanout;
    localparam int AW = 2;
`ifdef GPU_LINE_HEADER_EN
    localparam int LEN1 = 104;
    localparam int LEN3 = 296;
    localparam int RST_BIT = 36;
`else
    localparam int LEN1 = 72;
    localparam int LEN3 = 200;
    localparam int RST_BIT = 20;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic frame_start = 1'b0;
    logic sel = 1'b0;

    logic d1_busy, d1_done, d1_rd, d1_clk, d1_data, d1_cs;
    logic [AW-1:0] d1_addr;
    logic [7:0] d1_rdata = 8'h00;
    logic [2:0] d1_state;
    logic d3_busy, d3_done, d3_rd, d3_clk, d3_data, d3_cs;
    logic [AW-1:0] d3_addr;
    logic [7:0] d3_rdata = 8'h00;
    logic [2:0] d3_state;

    logic [7:0] vram [4];
    logic [7:0] exp_q [$];

    int n_tests = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    gpu_scanout #(.FB_WIDTH(16), .FB_HEIGHT(2), .CLK_DIV(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .frame_start(frame_start),
        .busy(d1_busy), .frame_done(d1_done), .vram_rd_en(d1_rd), .vram_addr(d1_addr),
        .vram_rdata(d1_rdata), .lcd_clk(d1_clk), .lcd_data(d1_data), .lcd_cs(d1_cs),
        .dbg_state_o(d1_state)
    );

    gpu_scanout #(.FB_WIDTH(16), .FB_HEIGHT(2), .CLK_DIV(3)) dut3 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .frame_start(frame_start),
        .busy(d3_busy), .frame_done(d3_done), .vram_rd_en(d3_rd), .vram_addr(d3_addr),
        .vram_rdata(d3_rdata), .lcd_clk(d3_clk), .lcd_data(d3_data), .lcd_cs(d3_cs),
        .dbg_state_o(d3_state)
    );

    // Synchronous VRAM: data appears the cycle after the read strobe.
    always @(posedge sys_clk) begin
        if (d1_rd) d1_rdata <= vram[d1_addr];
        if (d3_rd) d3_rdata <= vram[d3_addr];
    end

    logic m_done, m_rd, m_clk, m_data, m_cs;
    logic [AW-1:0] m_addr;
    logic [2:0] m_state;
    assign m_done  = sel ? d3_done  : d1_done;
    assign m_rd    = sel ? d3_rd    : d1_rd;
    assign m_clk   = sel ? d3_clk   : d1_clk;
    assign m_data  = sel ? d3_data  : d1_data;
    assign m_cs    = sel ? d3_cs    : d1_cs;
    assign m_addr  = sel ? d3_addr  : d1_addr;
    assign m_state = sel ? d3_state : d1_state;

    int mon_cyc = 0, cs_cnt = 0, done_cnt = 0, start_cyc = 0;
    int chg_err = 0, lvl_err = 0, hi_run = 0, lo_run = 0;
    bit start_seen = 1'b0;
    logic prev_clk = 1'b0, prev_data = 1'b0, prev_cs = 1'b0;
    logic [2:0] prev_state = 3'd0;
    int cs_rise_q [$];
    int done_q [$];
    int fetch_q [$];
    logic [AW-1:0] addr_q [$];
    logic bits_q [$];

    always @(negedge sys_clk) begin
        mon_cyc++;
        if (frame_start && !start_seen) begin
            start_cyc = mon_cyc;
            start_seen = 1'b1;
        end
        if (m_cs) cs_cnt++;
        if (m_cs && !prev_cs) cs_rise_q.push_back(mon_cyc);
        if (m_done) begin
            done_cnt++;
            done_q.push_back(mon_cyc);
        end
        if (m_rd) begin
            addr_q.push_back(m_addr);
            fetch_q.push_back(mon_cyc);
        end
        if (m_clk && !prev_clk) bits_q.push_back(m_data);
        if (m_clk && prev_clk && m_data != prev_data) chg_err++;
        if (m_clk) hi_run++;
        else if (prev_clk) begin
            if (hi_run != (sel ? 3 : 1)) lvl_err++;
            hi_run = 0;
        end
        if (m_state == 3'd3) lo_run++;
        else if (prev_state == 3'd3) begin
            if (lo_run != (sel ? 3 : 1)) lvl_err++;
            lo_run = 0;
        end
        prev_clk = m_clk;
        prev_data = m_data;
        prev_cs = m_cs;
        prev_state = m_state;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        cs_cnt = 0; done_cnt = 0; chg_err = 0; lvl_err = 0;
        hi_run = 0; lo_run = 0; start_seen = 1'b0;
        cs_rise_q.delete(); done_q.delete(); fetch_q.delete();
        addr_q.delete(); bits_q.delete();
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        frame_start = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        clear_mon();
    endtask

    task automatic pulse_start();
        @(posedge sys_clk); #1 frame_start = 1'b1;
        @(posedge sys_clk); #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int c = 0;
        while (done_cnt < n && c < budget) begin
            @(negedge sys_clk);
            c++;
        end
        check("done_wait", 64'(done_cnt >= n), 64'd1);
    endtask

    // Expected serial stream, one byte per entry; headers carry the row index.
    task automatic build_exp();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
`ifdef GPU_LINE_HEADER_EN
            if (i % 2 == 0) exp_q.push_back(8'(i / 2));
`endif
            exp_q.push_back(vram[i]);
        end
    endtask

    task automatic check_stream();
        logic [7:0] got;
        build_exp();
        check("bit_count", 64'(bits_q.size()), 64'(exp_q.size() * 8));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = 8'hxx;
            if (8 * i + 7 < bits_q.size())
                for (int b = 0; b < 8; b++) got[7 - b] = bits_q[8 * i + b];
            check($sformatf("stream_byte%0d", i), 64'(got), 64'(exp_q[i]));
        end
    endtask

    task automatic check_addrs(input int base);
        check("addr_count", 64'(addr_q.size()), 64'(base + 4));
        for (int i = 0; i < 4; i++)
            if (base + i < addr_q.size())
                check($sformatf("addr%0d", base + i), 64'(addr_q[base + i]), 64'(i));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        vram[0] = 8'hA5; vram[1] = 8'h3C; vram[2] = 8'hFF; vram[3] = 8'h00;

        // Reset: every output low on both instances.
        do_reset();
        @(negedge sys_clk);
        check("rst_out_d1", 64'({d1_busy, d1_done, d1_rd, d1_addr, d1_clk, d1_data, d1_cs}), 64'd0);
        check("rst_out_d3", 64'({d3_busy, d3_done, d3_rd, d3_addr, d3_clk, d3_data, d3_cs}), 64'd0);
        check("rst_state", 64'(d1_state), 64'd0);

        // Single frame, CLK_DIV=1.
        sel = 1'b0;
        do_reset();
        pulse_start();
        wait_done(1, 400);
        repeat (10) @(negedge sys_clk);
        check_addrs(0);
        check_stream();
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_cs_cycles", 64'(cs_cnt), 64'(LEN1));
        check("t1_frame_len", 64'(done_q[0] - cs_rise_q[0]), 64'(LEN1));
        check("t1_start_lat", 64'(cs_rise_q[0] - start_cyc), 64'd1);
`ifndef GPU_LINE_HEADER_EN
        check("t1_fetch_lat", 64'(fetch_q[0] - start_cyc), 64'd1);
`endif

        // Single frame, CLK_DIV=3.
        sel = 1'b1;
        do_reset();
        pulse_start();
        wait_done(1, 1000);
        repeat (10) @(negedge sys_clk);
        check_stream();
        check("t2_level_len", 64'(lvl_err), 64'd0);
        check("t2_data_stable", 64'(chg_err), 64'd0);
        check("t2_frame_len", 64'(done_q[0] - cs_rise_q[0]), 64'(LEN3));
        check("t2_cs_cycles", 64'(cs_cnt), 64'(LEN3));

        // Three requests mid-frame collapse into one back-to-back frame.
        sel = 1'b0;
        do_reset();
        pulse_start();
        repeat (8) @(posedge sys_clk);
        pulse_start();
        repeat (8) @(posedge sys_clk);
        pulse_start();
        repeat (8) @(posedge sys_clk);
        pulse_start();
        wait_done(2, 600);
        repeat (150) @(negedge sys_clk);
        check("t3_done_cnt", 64'(done_cnt), 64'd2);
        check("t3_frames", 64'(cs_rise_q.size()), 64'd2);
        check("t3_no_idle_gap", 64'(cs_rise_q[1] - done_q[0]), 64'd1);
        check_addrs(4);

        // Reset on bit 4 of byte 2 aborts the frame.
        do_reset();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(posedge sys_clk); #1;
            if (bits_q.size() >= RST_BIT && m_state == 3'd3) found = 1'b1;
        end
        check("t4_reach_bit", 64'(found), 64'd1);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check("t4_rst_out", 64'({d1_busy, d1_done, d1_rd, d1_addr, d1_clk, d1_data, d1_cs}), 64'd0);
        repeat (20) @(negedge sys_clk);
        check("t4_no_done", 64'(done_cnt), 64'd0);
        clear_mon();
        pulse_start();
        wait_done(1, 400);
        repeat (5) @(negedge sys_clk);
        check_addrs(0);
        check_stream();

        // Request in the DONE cycle restarts straight away.
        do_reset();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(posedge sys_clk); #1;
            if (m_state == 3'd5) begin
                frame_start = 1'b1;
                found = 1'b1;
            end
        end
        @(posedge sys_clk); #1 frame_start = 1'b0;
        check("t5_saw_done", 64'(found), 64'd1);
        wait_done(2, 400);
        repeat (150) @(negedge sys_clk);
        check("t5_done_cnt", 64'(done_cnt), 64'd2);
        check("t5_restart", 64'(cs_rise_q[1] - done_q[0]), 64'd1);
        check_addrs(4);
`ifndef GPU_LINE_HEADER_EN
        check("t5_fetch_after_done", 64'(fetch_q[4] - done_q[0]), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
